// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit packet sequencer: PID codes, FSM states
// and the USB CRC16 byte-update helper.
package usb_tx_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI
  } tx_state_e;

  function automatic logic is_handshake(input logic [3:0] code);
    return (code == PID_ACK) || (code == PID_NAK) || (code == PID_STALL);
  endfunction

  function automatic logic is_data(input logic [3:0] code);
    return (code == PID_DATA0) || (code == PID_DATA1);
  endfunction

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // USB sends LSB first, so the register shifts right against the reflected polynomial.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = c >> 1;
      if (fb) c = c ^ reflect16(CRC16_POLY);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// One-byte-per-cycle USB CRC16 register; clear has priority over enable.
module crc16_byte
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear)       crc_d = CRC16_INIT;
    else if (enable) crc_d = crc16_next(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packet_sequencer.sv
// Byte-level USB TX sequencer: SYNC, PID, FIFO payload and CRC16 over a
// valid/ready stream, flagging the final byte for EOP insertion.
module usb_tx_packet_sequencer
  import usb_tx_pkg::*;
#(
  parameter int         MAX_BYTES = 64,
  parameter int         SYNC_LEN  = 1,
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_packet,
  input  logic [LEN_W-1:0] tx_packet_length,
  input  logic [7:0]       tx_packet_data,
  output logic             get_tx_packet_data,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             byte_last,
  output logic             busy,
  output logic             tx_error
);

  localparam int                SYNC_W    = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BYTES);

  tx_state_e         state_q, state_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [3:0]        code_q, code_d;
  logic              tx_error_q, tx_error_d;
  logic              transfer, start_ok, crc_clear;
  logic [15:0]       crc;

  assign transfer = byte_valid & byte_ready;
  assign start_ok = is_handshake(tx_packet) |
                    (is_data(tx_packet) & (tx_packet_length <= MAX_LEN));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      code_q     <= '0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      code_q     <= code_d;
      tx_error_q <= tx_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    code_d     = code_q;
    tx_error_d = 1'b0;
    crc_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          if (start_ok) begin
            state_d    = ST_SYNC;
            sync_cnt_d = '0;
            byte_cnt_d = '0;
            code_d     = tx_packet;
            len_d      = tx_packet_length;
            crc_clear  = 1'b1;
          end else begin
            tx_error_d = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (transfer) begin
          if (sync_cnt_q == SYNC_LAST) state_d = ST_PID;
          else                         sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        end
      end
      ST_PID: begin
        if (transfer) begin
          byte_cnt_d = '0;
          if (is_handshake(code_q)) state_d = ST_IDLE;
          else if (len_q == '0)     state_d = ST_CRC_LO;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (transfer) begin
          if (byte_cnt_q == len_q - LEN_W'(1)) state_d = ST_CRC_LO;
          else                                 byte_cnt_d = byte_cnt_q + LEN_W'(1);
        end
      end
      ST_CRC_LO: if (transfer) state_d = ST_CRC_HI;
      ST_CRC_HI: if (transfer) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are Moore except in DATA, where the FIFO head passes straight through.
  always_comb begin
    byte_valid         = (state_q != ST_IDLE);
    busy               = (state_q != ST_IDLE);
    byte_out           = 8'h00;
    byte_last          = 1'b0;
    get_tx_packet_data = 1'b0;
    case (state_q)
      ST_SYNC:   byte_out = (sync_cnt_q == SYNC_LAST) ? SYNC_BYTE : 8'h00;
      ST_PID: begin
        byte_out  = {~code_q, code_q};
        byte_last = is_handshake(code_q);
      end
      ST_DATA: begin
        byte_out           = tx_packet_data;
        get_tx_packet_data = byte_ready;
      end
      ST_CRC_LO: byte_out = ~crc[7:0];
      ST_CRC_HI: begin
        byte_out  = ~crc[15:8];
        byte_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_error = tx_error_q;

  crc16_byte u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (crc_clear),
    .enable (get_tx_packet_data),
    .data   (tx_packet_data),
    .crc    (crc)
  );

endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// Randomised and directed bench for usb_tx_packet_sequencer, checked every cycle
// against a queue-of-expected-bytes model of the packet format.
module tb_usb_tx_packet_sequencer;

  localparam int SL = 1;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_packet = 4'h0;
  logic [6:0] tx_packet_length = 7'd0;
  logic [7:0] tx_packet_data = 8'h00;
  logic       byte_ready = 1'b0;
  logic       get_tx_packet_data, byte_valid, byte_last, busy, tx_error;
  logic [7:0] byte_out;

  logic       tx_start2 = 1'b0;
  logic [3:0] tx_packet2 = 4'h0;
  logic       byte_ready2 = 1'b1;
  logic       get2, valid2, last2, busy2, err2;
  logic [7:0] byte_out2;

  always #5 clk = ~clk;

  usb_tx_packet_sequencer dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
    .tx_packet_length(tx_packet_length), .tx_packet_data(tx_packet_data),
    .get_tx_packet_data(get_tx_packet_data), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
    .busy(busy), .tx_error(tx_error)
  );

  usb_tx_packet_sequencer #(.SYNC_LEN(4)) dut_hs (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start2), .tx_packet(tx_packet2),
    .tx_packet_length(7'd0), .tx_packet_data(8'h00),
    .get_tx_packet_data(get2), .byte_out(byte_out2),
    .byte_valid(valid2), .byte_ready(byte_ready2), .byte_last(last2),
    .busy(busy2), .tx_error(err2)
  );

  typedef struct packed { logic [7:0] b; logic pay; } ent_t;

  int         total = 0;
  int         bad = 0;
  ent_t       exp_q[$];
  logic       exp_err = 1'b0;
  logic [7:0] fifo[$];
  int         fifo_idx = 0;
  logic [7:0] next_pay[$];
  logic [7:0] log_b[$];
  logic       log_l[$];
  int         pops, busy_cyc, err_cyc;

  logic       r_rst = 1'b0, r_start = 1'b0, r_rdy = 1'b1;
  logic [3:0] r_pkt = 4'h0;
  logic [6:0] r_len = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_usb(input logic [7:0] d[$]);
    logic [15:0] r = 16'hFFFF;
    foreach (d[i]) begin
      r = r ^ {8'h00, d[i]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return ~r;
  endfunction

  function automatic bit legal(input logic [3:0] c, input logic [6:0] l);
    case (c)
      4'd2, 4'd10, 4'd14: return 1'b1;
      4'd3, 4'd11:        return l <= 7'd64;
      default:            return 1'b0;
    endcase
  endfunction

  task automatic build(input logic [3:0] c, input logic [6:0] l);
    logic [15:0] cr;
    exp_q.delete();
    fifo.delete();
    fifo_idx = 0;
    for (int i = 0; i < SL; i++) exp_q.push_back('{b: (i == SL - 1) ? 8'h80 : 8'h00, pay: 1'b0});
    exp_q.push_back('{b: {~c, c}, pay: 1'b0});
    if (c[1:0] == 2'b11) begin
      for (int i = 0; i < int'(l); i++) begin
        fifo.push_back(i < next_pay.size() ? next_pay[i] : 8'($urandom));
        exp_q.push_back('{b: fifo[i], pay: 1'b1});
      end
      cr = crc_usb(fifo);
      exp_q.push_back('{b: cr[7:0], pay: 1'b0});
      exp_q.push_back('{b: cr[15:8], pay: 1'b0});
    end
  endtask

  // One clock: drive at the falling edge, compare 1ns later, then advance the model.
  task automatic step();
    logic [7:0] eb;
    logic ev, el, eg;
    @(negedge clk);
    n_rst = r_rst; tx_start = r_start; tx_packet = r_pkt;
    tx_packet_length = r_len; byte_ready = r_rdy;
    tx_packet_data = (fifo_idx < fifo.size()) ? fifo[fifo_idx] : 8'($urandom);
    #1;
    ev = exp_q.size() > 0;
    eb = ev ? exp_q[0].b : 8'h00;
    el = exp_q.size() == 1;
    eg = ev && exp_q[0].pay && r_rdy;
    check("byte_valid", byte_valid, ev);
    check("busy", busy, ev);
    check("byte_out", byte_out, eb);
    check("byte_last", byte_last, el);
    check("get", get_tx_packet_data, eg);
    check("tx_error", tx_error, exp_err);
    if (byte_valid && byte_ready) begin
      log_b.push_back(byte_out);
      log_l.push_back(byte_last);
    end
    if (get_tx_packet_data) pops++;
    if (busy) busy_cyc++;
    if (tx_error) err_cyc++;
    if (!r_rst) begin
      exp_q.delete(); fifo.delete(); fifo_idx = 0; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (exp_q.size() == 0) begin
        if (r_start) begin
          if (legal(r_pkt, r_len)) build(r_pkt, r_len);
          else exp_err = 1'b1;
        end
      end else if (r_rdy) begin
        if (exp_q[0].pay) fifo_idx++;
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic clear_log();
    log_b.delete(); log_l.delete();
    pops = 0; busy_cyc = 0; err_cyc = 0;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      step();
      n++;
    end
    check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic check_seq(input string name, input logic [7:0] gb[$], input logic gl[$],
                           input logic [7:0] e[$]);
    check({name, "_len"}, gb.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      check($sformatf("%s_b%0d", name, i), (i < gb.size()) ? {24'h0, gb[i]} : 32'hFFFF_FFFF, e[i]);
      check($sformatf("%s_l%0d", name, i), (i < gl.size()) ? {31'h0, gl[i]} : 32'hFFFF_FFFF,
            (i == e.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic start_pkt(input logic [3:0] c, input logic [6:0] l);
    r_pkt = c; r_len = l; r_start = 1'b1;
    step();
    r_start = 1'b0;
  endtask

  initial begin
    logic [7:0] e[$];
    logic [7:0] d[$];
    logic [15:0] cr;
    logic [7:0] prev_b;
    logic prev_stall;
    logic [7:0] hb[$];
    logic hl[$];

    r_rst = 1'b0; r_rdy = 1'b1;
    repeat (3) step();
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    r_rst = 1'b1;
    step();

    d.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    check("crc_model_check", crc_usb(d), 16'hB4C8);
    d.delete();
    check("crc_model_empty", crc_usb(d), 16'h0000);

    clear_log();
    start_pkt(4'b0010, 7'd0);
    run_idle(20);
    e = '{8'h80, 8'hD2};
    check_seq("ack", log_b, log_l, e);
    check("ack_pops", pops, 0);
    check("ack_busy", busy_cyc, 2);

    clear_log();
    start_pkt(4'b0011, 7'd0);
    run_idle(20);
    e = '{8'h80, 8'hC3, 8'h00, 8'h00};
    check_seq("d0len0", log_b, log_l, e);
    check("d0len0_pops", pops, 0);

    clear_log();
    next_pay = '{8'hA1, 8'hB2, 8'hC3};
    start_pkt(4'b1011, 7'd3);
    prev_stall = 1'b0; prev_b = 8'h00;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      r_rdy = ~r_rdy;
      step();
      if (prev_stall) check("stall_hold", byte_out, prev_b);
      prev_stall = byte_valid && !byte_ready;
      prev_b = byte_out;
    end
    check("d1_done", exp_q.size(), 0);
    r_rdy = 1'b1;
    cr = crc_usb(next_pay);
    e = '{8'h80, 8'h4B, 8'hA1, 8'hB2, 8'hC3, cr[7:0], cr[15:8]};
    check_seq("d1len3", log_b, log_l, e);
    check("d1_pops", pops, 3);

    clear_log();
    start_pkt(4'b0001, 7'd0);
    repeat (3) step();
    check("out_err_cycles", err_cyc, 1);
    check("out_busy", busy_cyc, 0);

    clear_log();
    start_pkt(4'b0011, 7'd65);
    repeat (3) step();
    check("len65_err_cycles", err_cyc, 1);
    check("len65_busy", busy_cyc, 0);

    clear_log();
    start_pkt(4'b1010, 7'd0);
    r_start = 1'b1; r_pkt = 4'b0010;
    step();
    r_start = 1'b0;
    run_idle(20);
    step();
    e = '{8'h80, 8'h5A};
    check_seq("busy_start", log_b, log_l, e);
    check("busy_start_err", err_cyc, 0);

    next_pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_pkt(4'b0011, 7'd4);
    for (int n = 0; n < 20 && !(exp_q.size() > 0 && exp_q[0].pay && fifo_idx == 1); n++) step();
    check("mid_reached", fifo_idx, 1);
    r_rst = 1'b0;
    step();
    r_rst = 1'b1;
    clear_log();
    step();
    check("mid_rst_valid", byte_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_get", get_tx_packet_data, 1'b0);
    check("mid_rst_out", byte_out, 8'h00);
    clear_log();
    start_pkt(4'b1010, 7'd0);
    run_idle(20);
    e = '{8'h80, 8'h5A};
    check_seq("nak_after_rst", log_b, log_l, e);
    check("nak_after_rst_pops", pops, 0);

    for (int it = 0; it < 60; it++) begin
      logic [3:0] c;
      logic [6:0] l;
      case ($urandom_range(0, 6))
        0: c = 4'd2;
        1: c = 4'd10;
        2: c = 4'd14;
        3: c = 4'd3;
        4: c = 4'd11;
        default: c = 4'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: l = 7'd64;
        1: l = 7'd65;
        2: l = 7'($urandom);
        default: l = 7'($urandom_range(0, 8));
      endcase
      next_pay.delete();
      for (int i = 0; i < int'(l); i++) next_pay.push_back(8'($urandom));
      r_rdy = 1'b1;
      start_pkt(c, l);
      for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
        r_rdy = ($urandom_range(0, 9) < 7);
        r_start = ($urandom_range(0, 9) == 0);
        r_pkt = 4'($urandom);
        r_len = 7'($urandom_range(0, 8));
        step();
      end
      r_start = 1'b0;
      check("rand_done", exp_q.size(), 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    @(negedge clk);
    tx_start2 = 1'b1; tx_packet2 = 4'b1110; byte_ready2 = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      tx_start2 = 1'b0;
      #1;
      if (valid2) begin
        hb.push_back(byte_out2);
        hl.push_back(last2);
      end
    end
    e = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h1E};
    check_seq("hs_stall", hb, hl, e);
    check("hs_pops", get2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_tx_packet_sequencer.md
# usb_tx_packet_sequencer

Byte-level packet sequencer for the USB transmit path, between the TX data FIFO / protocol controller and the bit serializer (NRZI/bit-stuff stage). On a start request it emits, over a valid/ready byte stream, the SYNC pattern, the PID derived from the 4-bit packet code, the payload bytes popped from the FIFO, and a running CRC16. It flags the final byte so the serializer appends EOP. It generalises the earlier combinational byte selector with a configurable SYNC length, bounded payload length, a real CRC16 and back-pressure.

## Interface
- MAX_BYTES, 64, maximum payload length in bytes
- SYNC_LEN, 1, number of SYNC bytes (1 = full speed, 4 = high speed)
- SYNC_BYTE, 8'h80, final SYNC byte; the preceding SYNC_LEN-1 bytes are 8'h00
- LEN_W, $clog2(MAX_BYTES+1), length field width (derived)

- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, synchronous, active-low
- tx_start  in  1  start request; sampled only in IDLE
- tx_packet  in  4  packet code; PID byte = {~tx_packet, tx_packet}
- tx_packet_length  in  LEN_W  payload byte count; used for DATA codes only
- tx_packet_data  in  8  FIFO head byte (first-word-fall-through)
- get_tx_packet_data  out  1  FIFO pop, one per transferred payload byte
- byte_out  out  8  byte to serializer
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  serializer accepts byte this cycle
- byte_last  out  1  qualifies the final byte of the packet
- busy  out  1  high in every state except IDLE
- tx_error  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI.
- Transfer: byte_valid & byte_ready in the same cycle. The state and counters advance only on a transfer.
- In IDLE, tx_start=1 and the code is legal:
  - latch tx_packet and tx_packet_length
  - clear the CRC to 16'hFFFF
  - go to SYNC with sync_cnt=0
- SYNC: byte_out = 8'h00 for sync_cnt < SYNC_LEN-1, then SYNC_BYTE. Go to PID after SYNC_LEN transfers.
- PID: byte_out = {~code, code}.
  - Handshake codes 0010 ACK, 1010 NAK, 1110 STALL: byte_last=1; go to IDLE.
  - Data codes (code[1:0]=2'b11, i.e. DATA0 0011, DATA1 1011): go to DATA, or straight to CRC_LO if length=0.
- DATA:
  - byte_out = tx_packet_data.
  - get_tx_packet_data = transfer (combinational, same cycle).
  - CRC updates with the transferred byte.
  - Byte counter counts up; after `length` transfers go to CRC_LO.
- CRC_LO / CRC_HI:
  - byte_out = ~crc[7:0], then ~crc[15:8].
  - byte_last=1 in CRC_HI.
  - Go to IDLE.
- CRC16 (USB): polynomial 16'h8005, reflected/LSB-first, init 16'hFFFF, output complemented.
- Start rejection: tx_error pulses one cycle and the block stays in IDLE, with no byte_valid and no pop, when:
  - the code is a token code (code[1:0]=2'b01), or
  - the code is any other undefined code, or
  - a DATA code has length > MAX_BYTES.
- tx_start while busy: ignored, with no error.
- Inputs tx_packet and tx_packet_length may change after the start cycle without effect.

## Timing
- Reset (n_rst=0 at a rising edge):
  - state IDLE
  - byte_out=8'h00, byte_valid=0, byte_last=0, get_tx_packet_data=0, busy=0, tx_error=0
  - counters and CRC cleared
- Reset mid-packet aborts immediately; no further pops.
- Start latency: tx_start in cycle t gives byte_valid=1 with the first SYNC byte in cycle t+1.
- Moore outputs: byte_out, byte_valid and byte_last depend only on registered state, counters and CRC, except in DATA, where byte_out follows tx_packet_data. byte_out is stable while byte_ready=0.
- With byte_ready tied high:
  - handshake packet: SYNC_LEN+1 valid cycles
  - data packet: SYNC_LEN+3+N valid cycles
- busy drops in the cycle after the last transfer. A new tx_start is accepted in that same cycle, so back-to-back packets have a 1-cycle gap.
- tx_error is asserted in cycle t+1.

## Structure
- Package usb_tx_pkg holds:
  - PID code constants (ACK, NAK, STALL, DATA0, DATA1, OUT, IN)
  - the state enum
  - CRC16_POLY, CRC16_INIT
- Sub-module crc16_byte:
  - inputs: clk, n_rst, clear, enable, data[7:0]
  - output: crc[15:0]
  - one-byte-per-cycle USB CRC16 register
  - instantiated once

## Test plan
- ACK (0010), byte_ready=1 → bytes 80, D2; byte_last on D2; no pop; busy high 2 cycles.
- DATA0 (0011), length 0 → bytes 80, C3, 00, 00; byte_last on the final 00; no pop.
- DATA1 (1011), length 3, FIFO A1 B2 C3, byte_ready toggling 1/0 →
  - bytes 80, 4B, A1, B2, C3, then CRC bytes matching the software CRC16 model
  - exactly 3 pops, each coincident with a transfer
  - byte_out unchanged on stalled cycles
- Rejections:
  - OUT (0001) → tx_error one cycle, busy stays 0
  - DATA0 with length 65 (MAX_BYTES=64) → tx_error one cycle, busy stays 0
  - tx_start during a busy packet → ignored
- n_rst=0 at the second payload byte → next edge all outputs 0 and IDLE; a following NAK sends 80, 5A correctly.
- Build with SYNC_LEN=4, STALL (1110) → bytes 00, 00, 00, 80, 1E; byte_last on 1E.
